mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the team's 4:1 data mux between four requesters. It turns a request vector into a one-hot grant and a registered 2-bit mux select. It registers the selected input onto a single output bus. Grant tenure is bounded so that one requester cannot starve the others. The block sits directly in front of the 4:1 mux and owns its select lines.

---
 rtl/mux4_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter that owns the select lines of a shared 4:1 data mux.
// A request vector becomes a registered one-hot grant and a 2-bit select;
// the selected requester's word is registered onto dout. Grant tenure is
// bounded by MAX_HOLD cycles whenever another requester is waiting.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req[3:0]   request per requester (bit k = requester k)
//   din        packed data, requester k at din[k*DW +: DW]
//   gnt[3:0]   registered one-hot grant, zero when idle
//   sel[1:0]   registered index of the current owner
//   dout       registered mux output
//   dout_valid dout carries a word from the current/just-finished owner
//   busy       high whenever gnt is non-zero
//
// state | meaning
// IDLE  | no owner; first requester found from ptr is granted next cycle
// GRANT | sel owns the mux; release, rotate or hold every cycle
module mux4_rr_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] din,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic [DW-1:0]   dout,
  output logic            dout_valid,
  output logic            busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t      state, state_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [3:0]  hold_cnt, hold_nxt;
  logic [3:0]  gnt_q, gnt_nxt;
  logic [1:0]  sel_q, sel_nxt;
  logic [3:0]  owner_bit;
  logic [3:0]  others;
  logic [2:0]  pick_ptr;
  logic [2:0]  pick_next;
  logic        leave;
  logic        take;
  logic [DW-1:0] din_sel;

  // Returns {found, index}; the lowest offset from start wins because it is
  // evaluated last.
  function automatic logic [2:0] rr_pick(input logic [1:0] start,
                                         input logic [3:0] r);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 4'd0;
      gnt_q    <= 4'd0;
      sel_q    <= 2'd0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt_q    <= gnt_nxt;
      sel_q    <= sel_nxt;
    end
  end

  always_comb begin
    owner_bit = 4'b0001 << sel_q;
    others    = req & ~owner_bit;
    pick_ptr  = rr_pick(ptr, req);
    // Excluding the owner covers both release (its bit is already 0) and
    // rotation (the owner must never win again).
    pick_next = rr_pick(sel_q + 2'd1, others);
    leave     = !req[sel_q] || ((hold_cnt == HOLD_MAX) && (|others));

    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt_q;
    sel_nxt   = sel_q;

    case (state)
      IDLE: begin
        if (pick_ptr[2]) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'b0001 << pick_ptr[1:0];
          sel_nxt   = pick_ptr[1:0];
          hold_nxt  = 4'd1;
        end
      end
      GRANT: begin
        if (leave) begin
          ptr_nxt = sel_q + 2'd1;
          if (pick_next[2]) begin
            gnt_nxt  = 4'b0001 << pick_next[1:0];
            sel_nxt  = pick_next[1:0];
            hold_nxt = 4'd1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'd0;
          end
        end else if (hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt  = gnt_q;
    sel  = sel_q;
    busy = (state == GRANT);
  end

  always_comb begin
    case (sel_q)
      2'd0:    din_sel = din[0*DW +: DW];
      2'd1:    din_sel = din[1*DW +: DW];
      2'd2:    din_sel = din[2*DW +: DW];
      default: din_sel = din[3*DW +: DW];
    endcase
    take = (state == GRANT) && req[sel_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= take;
      if (take) dout <= din_sel;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;
  localparam int DW = 8;
  localparam int MH = 4;

  logic          clk = 1'b1;
  logic          rst = 1'b1;
  logic [3:0]    req = 4'd0;
  logic [4*DW-1:0] din = '0;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;

  mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .sel(sel),
    .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          busy;
    logic          dv;
    logic [DW-1:0] dout;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 = nobody), tenure length, start point.
  int         m_owner = -1;
  int         m_ten   = 0;
  int         m_ptr   = 0;
  int         m_sel   = 0;
  logic [DW-1:0] m_dout = '0;
  logic       m_dv    = 1'b0;

  function automatic int search(input int start, input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    logic [3:0] rest;
    if (rst) begin
      m_owner = -1; m_ten = 0; m_ptr = 0; m_sel = 0; m_dout = '0; m_dv = 1'b0;
      return;
    end
    m_dv = (m_owner >= 0) && req[m_owner];
    if (m_dv) m_dout = din[m_owner*DW +: DW];
    if (m_owner < 0) begin
      w = search(m_ptr, req);
      if (w >= 0) begin m_owner = w; m_sel = w; m_ten = 1; end
    end else begin
      rest = req;
      rest[m_owner] = 1'b0;
      if (!req[m_owner] || (m_ten >= MH && rest != 4'd0)) begin
        m_ptr = (m_owner + 1) % 4;
        w = search(m_ptr, rest);
        if (w >= 0) begin m_owner = w; m_sel = w; m_ten = 1; end
        else m_owner = -1;
      end else begin
        m_ten = (m_ten + 1 > MH) ? MH : m_ten + 1;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] q, input logic [4*DW-1:0] d);
    exp_t e;
    @(negedge clk);
    rst = r; req = q; din = d;
    model_step();
    e.gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'd0;
    e.sel  = 2'(m_sel);
    e.busy = (m_owner >= 0);
    e.dv   = m_dv;
    e.dout = m_dout;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt", int'(gnt), int'(e.gnt));
        chk("sel", int'(sel), int'(e.sel));
        chk("busy", int'(busy), int'(e.busy));
        chk("dout_valid", int'(dout_valid), int'(e.dv));
        chk("dout", int'(dout), int'(e.dout));
        chk("gnt_onehot", int'($countones(gnt) <= 1), 1);
      end
    end
  end

  initial begin : driver
    logic [3:0] rq;
    logic [4*DW-1:0] d;
    // reset
    cyc(1, 4'b0000, '0);
    cyc(1, 4'b0000, '0);
    // single requester 2
    d = '0; d[2*DW +: DW] = 8'hA5;
    repeat (3) cyc(0, 4'b0100, d);
    repeat (2) cyc(0, 4'b0000, d);
    // full contention
    repeat (24) cyc(0, 4'b1111, {$urandom});
    cyc(0, 4'b0000, '0);
    // lone hog
    repeat (10) cyc(0, 4'b0010, {$urandom});
    cyc(0, 4'b0000, '0);
    // wrap-around
    repeat (2) cyc(0, 4'b1000, {$urandom});
    cyc(0, 4'b0000, '0);
    repeat (3) cyc(0, 4'b0101, {$urandom});
    repeat (3) cyc(0, 4'b0100, {$urandom});
    cyc(0, 4'b0000, '0);
    // reset mid-tenure
    repeat (3) cyc(0, 4'b0100, {$urandom});
    cyc(1, 4'b0100, {$urandom});
    repeat (3) cyc(0, 4'b1010, {$urandom});
    cyc(0, 4'b0000, '0);
    // back-to-back handoff
    repeat (2) cyc(0, 4'b0001, {$urandom});
    cyc(0, 4'b1001, {$urandom});
    repeat (3) cyc(0, 4'b1000, {$urandom});
    cyc(0, 4'b0000, '0);
    // random traffic
    rq = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, 3)] ^= 1'b1;
      cyc(($urandom_range(0, 299) == 0), rq, {$urandom});
    end
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
